tl_sched_cntr: RTL and testbench

Timed, demand-driven scheduler for a two-street intersection. It extends the basic sensor-driven light sequencer with dwell timers (minimum and maximum green, fixed yellow, all-red clearance) and a latched pedestrian request served during street B's green. It sits between the street sensors and pedestrian push-button on one side and the lamp drivers on the other. Its La/Lb colour encoding is the codebase's existing one.

---
 rtl/tl_pkg.sv | 18 +
 rtl/tl_dwell_timer.sv | 26 ++
 rtl/tl_sched_cntr.sv | 101 ++++++++++
 tb/tb_tl_sched_cntr.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared lamp colour encoding and scheduler state encoding for the
// traffic-light blocks.
package tl_pkg;

    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] RED    = 2'b10;

    typedef enum logic [2:0] {
        A_GRN = 3'd0,
        A_YEL = 3'd1,
        AR_AB = 3'd2,
        B_GRN = 3'd3,
        B_YEL = 3'd4,
        AR_BA = 3'd5
    } state_e;

endpackage

// File: rtl/tl_dwell_timer.sv
// Saturating dwell counter: reads 0 in the first cycle of a phase and
// climbs by one per cycle, sticking at all-ones.
module tl_dwell_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples pre-edge values regardless of process order.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            count_q <= '0;
        end else if (count_q != '1) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/tl_sched_cntr.sv
// Timed two-street light scheduler with min/max green, yellow, all-red
// clearance and a latched pedestrian request served on street B's green.
module tl_sched_cntr
    import tl_pkg::*;
#(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 8,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int CNT_W     = $clog2(GREEN_MAX + 1)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       Ta,
    input  logic       Tb,
    input  logic       ped_req,
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic       walk,
    output logic [2:0] phase
);

    localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALLRED_T - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] t;
    logic             ped_pend_q, ped_pend_d;
    logic             walk_q, walk_d;
    logic             demand_b;
    logic             enter_b;

    // Any phase change restarts the dwell count in the new phase.
    tl_dwell_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state_d != state_q),
        .count   (t)
    );

    assign demand_b = Tb | ped_pend_q;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            A_GRN: if (t >= GMIN_LAST && demand_b && (!Ta || t >= GMAX_LAST)) state_d = A_YEL;
            A_YEL: if (t == YEL_LAST) state_d = AR_AB;
            AR_AB: if (t == AR_LAST)  state_d = B_GRN;
            B_GRN: if (t >= GMIN_LAST && Ta && (!Tb || t >= GMAX_LAST)) state_d = B_YEL;
            B_YEL: if (t == YEL_LAST) state_d = AR_BA;
            AR_BA: if (t == AR_LAST)  state_d = A_GRN;
            default:                  state_d = A_GRN;
        endcase
    end

    assign enter_b = (state_q == AR_AB) && (state_d == B_GRN);

    // A request coinciding with the entry edge is served now, not deferred.
    always_comb begin
        ped_pend_d = ped_pend_q | ped_req;
        walk_d     = 1'b0;
        if (enter_b) begin
            ped_pend_d = 1'b0;
            walk_d     = ped_pend_q | ped_req;
        end else if (state_q == B_GRN && state_d == B_GRN) begin
            walk_d = walk_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= A_GRN;
            ped_pend_q <= 1'b0;
            walk_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ped_pend_q <= ped_pend_d;
            walk_q     <= walk_d;
        end
    end

    always_comb begin
        La = RED;
        Lb = RED;
        case (state_q)
            A_GRN:   La = GREEN;
            A_YEL:   La = YELLOW;
            B_GRN:   Lb = GREEN;
            B_YEL:   Lb = YELLOW;
            default: ;
        endcase
    end

    assign walk  = walk_q;
    assign phase = state_q;

endmodule

// File: tb/tb_tl_sched_cntr.sv
// Directed bench for tl_sched_cntr: phase/lamp/walk sequences with
// hand-computed expectations for the default timing parameters.
module tb_tl_sched_cntr;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       Ta = 1'b0;
    logic       Tb = 1'b0;
    logic       ped_req = 1'b0;
    logic [1:0] La, Lb;
    logic       walk;
    logic [2:0] phase;

    int n_checks = 0;
    int n_errors = 0;

    tl_sched_cntr dut (
        .clk     (clk),
        .reset_n (reset_n),
        .Ta      (Ta),
        .Tb      (Tb),
        .ped_req (ped_req),
        .La      (La),
        .Lb      (Lb),
        .walk    (walk),
        .phase   (phase)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Lamp colours the spec assigns to each phase code, as {La, Lb}.
    function automatic logic [3:0] lamps(input logic [2:0] ph);
        case (ph)
            3'd0:    lamps = 4'b00_10;
            3'd1:    lamps = 4'b01_10;
            3'd3:    lamps = 4'b10_00;
            3'd4:    lamps = 4'b10_01;
            default: lamps = 4'b10_10;
        endcase
    endfunction

    // Phase sequence after reset with Tb=1, Ta=0: 4 green, 2 yellow, 1 all-red.
    function automatic logic [2:0] tb_only_phase(input int c);
        if (c < 4)      tb_only_phase = 3'd0;
        else if (c < 6) tb_only_phase = 3'd1;
        else if (c < 7) tb_only_phase = 3'd2;
        else            tb_only_phase = 3'd3;
    endfunction

    // Checks the current cycle's outputs (sampled on the falling edge), then
    // advances to the next falling edge.
    task automatic cyc(input string tag, input int c, input logic [2:0] ph, input logic w);
        logic [3:0] l;
        l = lamps(ph);
        check($sformatf("%s c%0d phase", tag, c), 8'(phase), 8'(ph));
        check($sformatf("%s c%0d La", tag, c), 8'(La), 8'(l[3:2]));
        check($sformatf("%s c%0d Lb", tag, c), 8'(Lb), 8'(l[1:0]));
        check($sformatf("%s c%0d walk", tag, c), 8'(walk), 8'(w));
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        Ta = 1'b0;
        Tb = 1'b0;
        ped_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [2:0] ph;
        int         pos;

        @(negedge clk);

        // Rest in A_GRN with only Ta; long enough for the timer to saturate,
        // then B demand must switch at once (a wrapping timer would stall).
        do_reset();
        Ta = 1'b1;
        for (int c = 0; c < 33; c++) cyc("restA", c, 3'd0, 1'b0);
        Ta = 1'b0;
        Tb = 1'b1;
        cyc("restA", 33, 3'd0, 1'b0);
        cyc("restA", 34, 3'd1, 1'b0);
        cyc("restA", 35, 3'd1, 1'b0);
        cyc("restA", 36, 3'd2, 1'b0);
        cyc("restA", 37, 3'd3, 1'b0);

        // Tb only: minimum green, then rest in B_GRN.
        do_reset();
        Tb = 1'b1;
        for (int c = 0; c < 16; c++) cyc("tbonly", c, tb_only_phase(c), 1'b0);

        // Both streets busy: max green on each side, period 22.
        do_reset();
        Ta = 1'b1;
        Tb = 1'b1;
        for (int c = 0; c < 44; c++) begin
            pos = c % 22;
            if (pos < 8)       ph = 3'd0;
            else if (pos < 10) ph = 3'd1;
            else if (pos < 11) ph = 3'd2;
            else if (pos < 19) ph = 3'd3;
            else if (pos < 21) ph = 3'd4;
            else               ph = 3'd5;
            cyc("both", c, ph, 1'b0);
        end

        // Single pedestrian pulse with Ta busy: served after max green.
        do_reset();
        Ta = 1'b1;
        for (int c = 0; c < 24; c++) begin
            ped_req = (c == 3);
            if (c == 5) check("ped pend latched", 8'(dut.ped_pend_q), 8'd1);
            if (c < 8)       cyc("ped", c, 3'd0, 1'b0);
            else if (c < 10) cyc("ped", c, 3'd1, 1'b0);
            else if (c < 11) cyc("ped", c, 3'd2, 1'b0);
            else if (c < 15) cyc("ped", c, 3'd3, 1'b1);
            else if (c < 17) cyc("ped", c, 3'd4, 1'b0);
            else if (c < 18) cyc("ped", c, 3'd5, 1'b0);
            else             cyc("ped", c, 3'd0, 1'b0);
        end
        check("ped pend cleared", 8'(dut.ped_pend_q), 8'd0);

        // Request on the AR_AB->B_GRN edge is served immediately.
        do_reset();
        Tb = 1'b1;
        for (int c = 0; c < 11; c++) begin
            ped_req = (c == 6);
            if (c == 7) check("edge ped pend", 8'(dut.ped_pend_q), 8'd0);
            cyc("edgeped", c, tb_only_phase(c), c >= 7);
        end

        // Request during B_GRN waits for the next B_GRN; current walk stays off.
        do_reset();
        Tb = 1'b1;
        for (int c = 0; c < 12; c++) begin
            ped_req = (c == 8);
            if (c == 9) check("late ped pend", 8'(dut.ped_pend_q), 8'd1);
            cyc("lateped", c, tb_only_phase(c), 1'b0);
        end

        // Reset while in B_YEL, then a fresh Tb request needs full min green.
        do_reset();
        Tb = 1'b1;
        for (int c = 0; c < 7; c++) cyc("midrst", c, tb_only_phase(c), 1'b0);
        Ta = 1'b1;
        Tb = 1'b0;
        for (int c = 7; c < 11; c++) cyc("midrst", c, 3'd3, 1'b0);
        reset_n = 1'b0;
        cyc("midrst", 11, 3'd4, 1'b0);
        reset_n = 1'b1;
        Ta = 1'b0;
        Tb = 1'b1;
        for (int c = 0; c < 4; c++) cyc("postrst", c, 3'd0, 1'b0);
        cyc("postrst", 4, 3'd1, 1'b0);

        // Illegal state code 7 recovers to A_GRN with the timer cleared.
        do_reset();
        Ta = 1'b1;
        for (int c = 0; c < 6; c++) cyc("illegal", c, 3'd0, 1'b0);
        dut.state_q = tl_pkg::state_e'(3'd7);
        #1;
        check("illegal forced phase", 8'(phase), 8'd7);
        @(negedge clk);
        check("illegal recover phase", 8'(phase), 8'd0);
        check("illegal recover t", 8'(dut.t), 8'd0);
        check("illegal recover La", 8'(La), 8'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
